// File: rtl/shift7_pkg.sv
// Shared definitions for the shift7 parallel-in / serial-out converter.
package shift7_pkg;

    localparam int unsigned SHIFT7_WIDTH = 7;

    // Minimum bits needed to count 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = value - 1;
        while (x != 0) begin
            r++;
            x = x >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    typedef logic [SHIFT7_WIDTH-1:0] word_t;

endpackage

// File: rtl/shift7_bitcnt.sv
// Mod-WIDTH bit counter for shift7; last_bit marks the final bit of a frame.
module shift7_bitcnt
    import shift7_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT7_WIDTH,
    localparam int unsigned CW = clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    output logic [CW-1:0] bitcnt,
    output logic          last_bit
);

    assign last_bit = (bitcnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt <= '0;
        end else if (restart || last_bit) begin
            bitcnt <= '0;
        end else begin
            bitcnt <= bitcnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift7.sv
// Free-running serializer: reloads datain every WIDTH clocks and shifts it
// out one bit per clock, MSB or LSB first.
module shift7
    import shift7_pkg::*;
#(
    parameter int unsigned WIDTH     = SHIFT7_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datain,
    output logic             dataout
);

    localparam int unsigned CW = clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             load_pending;
    logic             load;
    logic             bit_next;
    logic [CW-1:0]    bitcnt;
    logic             last_bit;

    shift7_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk     (clk),
        .rst     (rst),
        .restart (load_pending),
        .bitcnt  (bitcnt),
        .last_bit(last_bit)
    );

    assign load = load_pending | last_bit;

    // dataout is registered, so on a shift edge it takes the bit that sits
    // one place behind the output end of the held word.
    always_comb begin
        shreg_next = '0;
        bit_next   = 1'b0;
        if (load) begin
            shreg_next = datain;
            bit_next   = MSB_FIRST ? datain[WIDTH-1] : datain[0];
        end else if (MSB_FIRST) begin
            shreg_next = shreg << 1;
            bit_next   = shreg[WIDTH-2];
        end else begin
            shreg_next = shreg >> 1;
            bit_next   = shreg[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            dataout      <= 1'b0;
            load_pending <= 1'b1;
        end else begin
            shreg        <= shreg_next;
            dataout      <= bit_next;
            load_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (32'(bitcnt) < WIDTH);
        end
    end

endmodule

// File: tb/tb_shift7.sv
// Scoreboard bench for shift7: expected serial bits are queued when a word
// is driven and popped one per clock as the DUT shifts them out.
module tb_shift7;

    logic       clk;
    logic       rst;
    logic [6:0] din7;
    logic [6:0] dinl;
    logic [7:0] din8;
    logic       dout7;
    logic       doutl;
    logic       dout8;

    bit q7[$];
    bit ql[$];
    bit q8[$];

    int total;
    int bad;

    shift7 #(.WIDTH(7), .MSB_FIRST(1'b1)) dut7 (
        .clk(clk), .rst(rst), .datain(din7), .dataout(dout7)
    );

    shift7 #(.WIDTH(7), .MSB_FIRST(1'b0)) dutl (
        .clk(clk), .rst(rst), .datain(dinl), .dataout(doutl)
    );

    shift7 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst(rst), .datain(din8), .dataout(dout8)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push7_msb(input logic [6:0] w);
        for (int i = 6; i >= 0; i--) q7.push_back(w[i]);
    endtask

    task automatic push7_lsb(input logic [6:0] w);
        for (int i = 0; i < 7; i++) ql.push_back(w[i]);
    endtask

    task automatic push8_msb(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q8.push_back(w[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q7.delete();
        ql.delete();
        q8.delete();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        din7 = 7'b1110101;
        dinl = 7'b1110101;
        din8 = 8'hA5;
        #1;
        total += 3;
        if (dout7 !== 1'b0) begin bad++; $display("FAIL reset_pre_edge7: got %b want 0", dout7); end
        if (doutl !== 1'b0) begin bad++; $display("FAIL reset_pre_edgel: got %b want 0", doutl); end
        if (dout8 !== 1'b0) begin bad++; $display("FAIL reset_pre_edge8: got %b want 0", dout8); end
        #29;
        total += 3;
        if (dout7 !== 1'b0) begin bad++; $display("FAIL reset_held7: got %b want 0", dout7); end
        if (doutl !== 1'b0) begin bad++; $display("FAIL reset_held_l: got %b want 0", doutl); end
        if (dout8 !== 1'b0) begin bad++; $display("FAIL reset_held8: got %b want 0", dout8); end
        #20;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit exp;
        push7_msb(din7);
        push7_msb(din7);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q7.size() == 0) begin
                bad++;
                $display("FAIL basic_underflow: edge %0d got %b want queued bit", i + 1, dout7);
            end else begin
                exp = q7.pop_front();
                if (dout7 !== exp) begin
                    bad++;
                    $display("FAIL basic: edge %0d got %b want %b", i + 1, dout7, exp);
                end
            end
        end
    endtask

    task automatic test_mid_change();
        bit exp;
        din7 = 7'b1110101;
        do_reset();
        push7_msb(7'b1110101);
        push7_msb(7'b0000001);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q7.size() == 0) begin
                bad++;
                $display("FAIL mid_change_underflow: edge %0d got %b", i + 1, dout7);
            end else begin
                exp = q7.pop_front();
                if (dout7 !== exp) begin
                    bad++;
                    $display("FAIL mid_change: edge %0d got %b want %b", i + 1, dout7, exp);
                end
            end
            if (i == 2) din7 = 7'b0000001;
        end
    endtask

    task automatic test_reset_midframe();
        bit exp;
        din7 = 7'b1110101;
        do_reset();
        push7_msb(din7);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q7.size() == 0) begin
                bad++;
                $display("FAIL midreset_pre_underflow: edge %0d got %b", i + 1, dout7);
            end else begin
                exp = q7.pop_front();
                if (dout7 !== exp) begin
                    bad++;
                    $display("FAIL midreset_pre: edge %0d got %b want %b", i + 1, dout7, exp);
                end
            end
        end
        #9;
        rst = 1'b1;
        #1;
        total++;
        if (dout7 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: got %b want 0", dout7);
        end
        q7.delete();
        @(posedge clk);
        #1;
        total++;
        if (dout7 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_held: got %b want 0", dout7);
        end
        @(negedge clk);
        rst = 1'b0;
        push7_msb(din7);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q7.size() == 0) begin
                bad++;
                $display("FAIL midreset_restart_underflow: edge %0d got %b", i + 1, dout7);
            end else begin
                exp = q7.pop_front();
                if (dout7 !== exp) begin
                    bad++;
                    $display("FAIL midreset_restart: edge %0d got %b want %b", i + 1, dout7, exp);
                end
            end
        end
    endtask

    task automatic test_lsb_first();
        bit exp;
        dinl = 7'b1110101;
        do_reset();
        push7_lsb(dinl);
        push7_lsb(dinl);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (ql.size() == 0) begin
                bad++;
                $display("FAIL lsb_underflow: edge %0d got %b", i + 1, doutl);
            end else begin
                exp = ql.pop_front();
                if (doutl !== exp) begin
                    bad++;
                    $display("FAIL lsb_first: edge %0d got %b want %b", i + 1, doutl, exp);
                end
            end
        end
    endtask

    task automatic test_width8();
        bit exp;
        din8 = 8'hA5;
        do_reset();
        push8_msb(din8);
        push8_msb(din8);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL width8_underflow: edge %0d got %b", i + 1, dout8);
            end else begin
                exp = q8.pop_front();
                if (dout8 !== exp) begin
                    bad++;
                    $display("FAIL width8: edge %0d got %b want %b", i + 1, dout8, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp;
        din7 = 7'($urandom);
        do_reset();
        push7_msb(din7);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 7; i++) begin
                @(posedge clk);
                #1;
                total++;
                if (q7.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_underflow: frame %0d bit %0d got %b", f, i, dout7);
                end else begin
                    exp = q7.pop_front();
                    if (dout7 !== exp) begin
                        bad++;
                        $display("FAIL back_to_back: frame %0d bit %0d got %b want %b", f, i, dout7, exp);
                    end
                end
                if (i == 0) begin
                    din7 = 7'($urandom);
                    push7_msb(din7);
                end
            end
        end
        q7.delete();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_mid_change();
        test_reset_midframe();
        test_lsb_first();
        test_width8();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
